// File: rtl/intc.sv
// Interrupt controller: NSRC request lines, per-source edge/level mode,
// enable mask, global enable, pending register with write-1-to-clear
// (edge sources) and a fixed-priority vector register.
// Bus reads are registered into dbr. irq is registered.
module intc #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [7:0]      dbr,
    input  logic [7:0]      dbw,
    input  logic [1:0]      addr,
    input  logic            cs,
    input  logic            we,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_ENA  = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_rise;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_ena;
    logic [NSRC-1:0] r_mode;
    logic            r_ge;
    logic            r_irq;
    logic [7:0]      r_dbr;

    logic            w_wr_pend;
    logic            w_wr_ena;
    logic            w_wr_mode;
    logic            w_wr_ctrl;
    logic            w_rd;
    logic [NSRC-1:0] w_pend_next;
    logic [NSRC-1:0] w_pe;
    logic [7:0]      w_vec;
    logic [7:0]      w_rd_data;

    assign w_wr_pend = cs & we & (addr == ADDR_PEND);
    assign w_wr_ena  = cs & we & (addr == ADDR_ENA);
    assign w_wr_mode = cs & we & (addr == ADDR_MODE);
    assign w_wr_ctrl = cs & we & (addr == ADDR_CTRL);
    assign w_rd      = cs & ~we;
    assign w_pe      = r_pend & r_ena;

    // Per-source pending logic. Edge sources latch the registered rise
    // pulse and hold until a 1 is written; a set arriving together with a
    // clear wins. Level sources simply mirror the synchronised input, so
    // both modes present PEND one edge after src_q.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_pend
            logic w_clr;
            assign w_clr = w_wr_pend & dbw[gi];
            assign w_pend_next[gi] = r_mode[gi]
                                   ? (r_rise[gi] | (r_pend[gi] & ~w_clr))
                                   : r_src_q[gi];
        end
    endgenerate

    // Sample the request lines and register the rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_q <= '0;
            r_rise  <= '0;
        end else begin
            r_src_q <= src;
            r_rise  <= src & ~r_src_q;
        end
    end

    // Control/status registers; bus writes take effect on the write edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            r_ena  <= '0;
            r_mode <= '0;
            r_ge   <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_wr_ena)  r_ena  <= dbw[NSRC-1:0];
            if (w_wr_mode) r_mode <= dbw[NSRC-1:0];
            if (w_wr_ctrl) r_ge   <= dbw[0];
        end
    end

    // Lowest-numbered pending-and-enabled source wins; 0x80 when none.
    always_comb begin
        w_vec = 8'h80;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_pe[i]) w_vec = {5'd0, 3'(i)};
        end
    end

    // Read mux; bits above NSRC are forced to zero.
    always_comb begin
        w_rd_data = 8'h00;
        case (addr)
            ADDR_PEND: w_rd_data[NSRC-1:0] = r_pend;
            ADDR_ENA:  w_rd_data[NSRC-1:0] = r_ena;
            ADDR_MODE: w_rd_data[NSRC-1:0] = r_mode;
            default:   w_rd_data = w_vec;
        endcase
    end

    // Interrupt output, computed from the register values before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ge & (|w_pe);
        end
    end

    // Registered read data; holds when no read is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbr <= 8'h00;
        end else if (w_rd) begin
            r_dbr <= w_rd_data;
        end
    end

    assign irq = r_irq;
    assign dbr = r_dbr;

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: edge latch, priority, set/clear collision,
// level/masking, asynchronous reset and unused-bit behaviour (NSRC=3).
`timescale 1ns/1ps
module tb_intc;

    logic       clk;
    logic       rst;
    logic [7:0] dbw;
    logic [1:0] addr;
    logic       cs;
    logic       we;
    logic [3:0] src;
    logic [2:0] src3;
    logic [7:0] dbr;
    logic [7:0] dbr3;
    logic       irq;
    logic       irq3;

    int n_cmp;
    int n_bad;

    intc #(.NSRC(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .dbr  (dbr),
        .dbw  (dbw),
        .addr (addr),
        .cs   (cs),
        .we   (we),
        .src  (src),
        .irq  (irq)
    );

    intc #(.NSRC(3)) u_dut3 (
        .clk  (clk),
        .rst  (rst),
        .dbr  (dbr3),
        .dbw  (dbw),
        .addr (addr),
        .cs   (cs),
        .we   (we),
        .src  (src3),
        .irq  (irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, report on mismatch.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%02h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; dbw = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        cs = 1'b0;
        check(tag, dbr, exp);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; dbw = 8'h00;
        src = 4'h0; src3 = 3'h0;

        #3;
        check("reset_irq", {7'd0, irq}, 8'h00);
        check("reset_dbr", dbr, 8'h00);
        check("reset_dbr3", dbr3, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Edge latch on source 2
        wr(2'd2, 8'h0F);
        wr(2'd1, 8'h0F);
        wr(2'd3, 8'h01);
        src = 4'h4;
        tick();
        src = 4'h0;
        tick();
        check("edge_irq_e1", {7'd0, irq}, 8'h00);
        tick();
        check("edge_irq_e2", {7'd0, irq}, 8'h01);
        rd("edge_pend", 2'd0, 8'h04);
        rd("edge_vec", 2'd3, 8'h02);
        check("edge_irq_after_rd", {7'd0, irq}, 8'h01);
        wr(2'd0, 8'h04);
        check("clr_irq_same_edge", {7'd0, irq}, 8'h01);
        tick();
        check("clr_irq_next_edge", {7'd0, irq}, 8'h00);

        // Fixed priority
        src = 4'hA;
        tick();
        src = 4'h0;
        tick();
        tick();
        rd("prio_vec_1", 2'd3, 8'h01);
        wr(2'd0, 8'h02);
        rd("prio_vec_3", 2'd3, 8'h03);
        wr(2'd0, 8'h08);
        rd("prio_vec_none", 2'd3, 8'h80);
        check("prio_irq_off", {7'd0, irq}, 8'h00);

        // Set and clear on the same edge: set wins
        src = 4'h1;
        tick();
        src = 4'h0;
        tick();
        tick();
        check("coll_irq_before", {7'd0, irq}, 8'h01);
        src = 4'h1;
        tick();
        src = 4'h0;
        wr(2'd0, 8'h01);
        check("coll_irq_at_wr", {7'd0, irq}, 8'h01);
        rd("coll_pend", 2'd0, 8'h01);
        check("coll_irq_after", {7'd0, irq}, 8'h01);
        wr(2'd0, 8'h01);

        // Level mode and masking
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h00);
        src = 4'h2;
        tick(); tick(); tick();
        check("lvl_masked_irq", {7'd0, irq}, 8'h00);
        rd("lvl_pend", 2'd0, 8'h02);
        wr(2'd1, 8'h02);
        tick();
        check("lvl_ena_irq", {7'd0, irq}, 8'h01);
        wr(2'd0, 8'h02);
        rd("lvl_w1c_noeffect", 2'd0, 8'h02);
        wr(2'd3, 8'h00);
        tick();
        check("lvl_ge0_irq", {7'd0, irq}, 8'h00);
        wr(2'd3, 8'h01);
        tick();
        check("lvl_ge1_irq", {7'd0, irq}, 8'h01);
        src = 4'h0;
        tick();
        tick();
        check("lvl_fall_irq_e1", {7'd0, irq}, 8'h01);
        tick();
        check("lvl_fall_irq_e2", {7'd0, irq}, 8'h00);
        rd("lvl_fall_pend", 2'd0, 8'h00);

        // Asynchronous reset mid-operation
        wr(2'd1, 8'h05);
        src = 4'h5;
        tick(); tick(); tick();
        check("rst_pre_irq", {7'd0, irq}, 8'h01);
        rd("rst_pre_pend", 2'd0, 8'h05);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_irq", {7'd0, irq}, 8'h00);
        check("rst_async_dbr", dbr, 8'h00);
        src = 4'h0;
        #1;
        rst = 1'b1;
        tick();
        rd("rst_pend", 2'd0, 8'h00);
        rd("rst_ena", 2'd1, 8'h00);
        rd("rst_mode", 2'd2, 8'h00);
        rd("rst_vec", 2'd3, 8'h80);

        // Unused bits with NSRC=3
        wr(2'd1, 8'hFF);
        rd("n4_ena", 2'd1, 8'h0F);
        check("n3_ena", dbr3, 8'h07);
        wr(2'd2, 8'hFF);
        rd("n4_mode", 2'd2, 8'h0F);
        check("n3_mode", dbr3, 8'h07);
        wr(2'd2, 8'h00);
        src3 = 3'h7;
        tick(); tick(); tick();
        rd("n4_pend_idle", 2'd0, 8'h00);
        check("n3_pend", dbr3, 8'h07);
        rd("n4_vec_idle", 2'd3, 8'h80);
        check("n3_vec", dbr3, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources; legal range 1..8.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; port named rst as on all blocks in this codebase; low clears all state immediately.
REQ-004 dbr  output  8  registered read data to the CPU bus mux.
REQ-005 dbw  input  8  write data from the CPU.
REQ-006 addr  input  2  register select.
REQ-007 cs  input  1  chip select; an access occurs only when cs=1.
REQ-008 we  input  1  1=write, 0=read; qualified by cs.
REQ-009 src  input  NSRC  interrupt request lines from peripherals (timer, uart, ...), active-high, synchronous to clk.
REQ-010 irq  output  1  registered, active-high interrupt request to the CPU IRQ input.

Function
REQ-011 Register map: 0=PEND, 1=ENA, 2=MODE, 3=CTRL(write)/VEC(read); bits at index >= NSRC shall read 0 and ignore writes.
REQ-012 src shall be registered every cycle into src_q for edge detection.
REQ-013 MODE bit i=1 (edge): PEND[i] shall set on the edge where src[i]=1 and src_q[i]=0, then hold until cleared.
REQ-014 MODE bit i=0 (level): PEND[i] shall equal src_q[i] each cycle; write-1-to-clear has no effect on it.
REQ-015 Write PEND: each dbw bit =1 shall clear the corresponding edge-mode PEND bit; 0 bits leave it unchanged.
REQ-016 If set (REQ-013) and clear (REQ-015) hit the same PEND bit in the same cycle, set wins; PEND bit = 1.
REQ-017 Writes to ENA and MODE shall load dbw[NSRC-1:0] directly.
REQ-018 Changing a MODE bit from 1 to 0 shall make PEND follow src_q from the next edge; changing 0 to 1 shall keep the current PEND value latched.
REQ-019 Write CTRL: dbw[0] shall load global enable GE; other bits are ignored.
REQ-020 VEC read value: index (bits[2:0]) of the lowest-numbered bit of PEND & ENA, bit7=0; if none set, 0x80.
REQ-021 irq shall be registered as GE & |(PEND & ENA), using the PEND/ENA values before the current edge.
REQ-022 Latency, edge mode: src rises before edge E0 -> src_q=1 at E0 -> PEND=1 at E1 -> irq=1 at E2.
REQ-023 Latency, level mode: irq shall assert at E2 after src rises, and deassert two edges after src falls.
REQ-024 Read: on an edge with cs=1 and we=0, dbr shall load the register selected by addr; otherwise dbr holds.
REQ-025 Reads shall have no side effects; reading PEND or VEC does not clear anything.
REQ-026 Write timing: a write on edge E shall take effect at E; irq shall reflect it at E+1.
REQ-027 A write with cs=0 shall change no state.
REQ-028 Priority is fixed: lowest index wins; there is no rotation.

Reset
REQ-029 On rst=0, immediately: PEND=0, ENA=0, MODE=0 (level), GE=0, src_q=0, irq=0, dbr=0x00.
REQ-030 Reset asserted mid-operation shall drop irq asynchronously, without waiting for a clock edge.
REQ-031 After rst returns high, the first edge shall sample src normally; a src already high counts as a rising edge (src_q=0).

Verification
REQ-032 Edge latch: MODE=0x0F, ENA=0x0F, GE=1; pulse src[2] for 1 cycle -> PEND=0x04, VEC=0x02, irq=1 two edges after the pulse; write PEND=0x04 -> irq=0 one edge later.
REQ-033 Priority: edge mode, src[3] and src[1] pulse together -> VEC=0x01; clear bit 1 -> VEC=0x03; clear bit 3 -> VEC=0x80, irq=0.
REQ-034 Set/clear collision: src[0] rises on the same edge as a PEND write of 0x01 -> PEND[0]=1 and irq stays 1.
REQ-035 Level and masking: MODE=0, src=0x02 held; ENA=0x00 -> irq=0; ENA=0x02 -> irq=1; GE=0 -> irq=0; src=0 with GE=1 -> PEND=0, irq=0 two edges later.
REQ-036 Reset mid-operation: irq=1 with PEND=0x05; assert rst between clock edges -> irq=0 and dbr=0 with no clock edge; all registers read 0x00, VEC reads 0x80 after release.
REQ-037 Unused bits with NSRC=3: write 0xFF to ENA -> ENA reads 0x07; src[3..7] do not exist and no bit >= 3 ever reads 1.
